// File: rtl/reg_wb_queue.sv
// -----------------------------------------------------------------------------
// reg_wb_queue
//   Write-back queue in front of the 32x32 register bank. Results from the
//   memory-load path and the ALU arrive over valid/ready, are queued in FIFO
//   order (load first when both land on the same edge), and are retired at
//   most one per cycle as a registered one-hot write enable plus data.
//   A pending-destination mask is exported for upstream hazard detection.
//
// Ports
//   Clk        in   1    rising-edge clock
//   Rst        in   1    synchronous active-high reset
//   Mem_Valid  in   1    load result offered
//   Mem_Rd     in   5    load destination register
//   Mem_Data   in   DW   load result
//   Mem_Ready  out  1    load result accepted at this edge if valid
//   Alu_Valid  in   1    ALU result offered
//   Alu_Rd     in   5    ALU destination register
//   Alu_Data   in   DW   ALU result
//   Alu_Ready  out  1    ALU result accepted at this edge if valid
//   D          out  DW   write data to the register bank
//   En         out  32   one-hot write enable (bit 0 never set)
//   Pend       out  32   destinations queued or being written this cycle
//   Busy       out  1    queue non-empty or a write on En
// -----------------------------------------------------------------------------
module reg_wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Mem_Valid,
    input  logic [4:0]    Mem_Rd,
    input  logic [DW-1:0] Mem_Data,
    output logic          Mem_Ready,
    input  logic          Alu_Valid,
    input  logic [4:0]    Alu_Rd,
    input  logic [DW-1:0] Alu_Data,
    output logic          Alu_Ready,
    output logic [DW-1:0] D,
    output logic [31:0]   En,
    output logic [31:0]   Pend,
    output logic          Busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    function automatic logic [31:0] f_onehot(input logic [4:0] rd);
        return (rd == 5'd0) ? 32'd0 : (32'd1 << rd);
    endfunction

    // Queue storage (data path, not reset)
    logic [4:0]    r_rd  [DEPTH];
    logic [DW-1:0] r_dat [DEPTH];

    // Control state
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_en;
    logic [DW-1:0] r_d;

    logic [CW-1:0] w_free;
    logic          w_mem_push;
    logic          w_alu_push;
    logic          w_pop;
    logic [AW-1:0] w_alu_wp;
    logic [31:0]   w_pend;

    // Readiness uses only the pre-edge count: a pop on the same edge does
    // not free a slot early. The ALU only takes the last free slot when the
    // load path is not competing for it.
    assign w_free     = CW'(DEPTH) - r_cnt;
    assign Mem_Ready  = !Rst && (w_free >= CW'(1));
    assign Alu_Ready  = !Rst && ((w_free >= CW'(2)) || ((w_free == CW'(1)) && !Mem_Valid));
    assign w_mem_push = Mem_Valid && Mem_Ready;
    assign w_alu_push = Alu_Valid && Alu_Ready;
    assign w_pop      = (r_cnt != '0);
    // ALU entry lands behind the load entry when both are accepted together
    assign w_alu_wp   = w_mem_push ? (r_wp + AW'(1)) : r_wp;

    always_ff @(posedge Clk) begin
        if (w_mem_push) begin
            r_rd[r_wp]  <= Mem_Rd;
            r_dat[r_wp] <= Mem_Data;
        end
        if (w_alu_push) begin
            r_rd[w_alu_wp]  <= Alu_Rd;
            r_dat[w_alu_wp] <= Alu_Data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_en  <= '0;
            r_d   <= '0;
        end else begin
            r_wp  <= r_wp + AW'(w_mem_push) + AW'(w_alu_push);
            r_cnt <= r_cnt + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
                r_en <= f_onehot(r_rd[r_rp]);
                r_d  <= r_dat[r_rp];
            end else begin
                r_en <= '0;
            end
        end
    end

    // Pending mask: OR of every occupied slot's destination plus the write
    // currently on En, so a duplicate Rd stays flagged until its last copy
    // has been written.
    always_comb begin
        w_pend = r_en;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < r_cnt) begin
                w_pend = w_pend | f_onehot(r_rd[r_rp + AW'(i)]);
            end
        end
        w_pend[0] = 1'b0;
    end

    assign Pend = w_pend;
    assign En   = r_en;
    assign D    = r_d;
    assign Busy = (r_cnt != '0) || (r_en != '0);

endmodule

// File: tb/tb_reg_wb_queue.sv
module tb_reg_wb_queue;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Mem_Valid;
    logic [4:0]  Mem_Rd;
    logic [31:0] Mem_Data;
    logic        Mem_Ready;
    logic        Alu_Valid;
    logic [4:0]  Alu_Rd;
    logic [31:0] Alu_Data;
    logic        Alu_Ready;
    logic [31:0] D;
    logic [31:0] En;
    logic [31:0] Pend;
    logic        Busy;

    int n_checks = 0;
    int n_fail   = 0;

    reg_wb_queue #(.DEPTH(4), .DW(32)) dut (
        .Clk(Clk), .Rst(Rst),
        .Mem_Valid(Mem_Valid), .Mem_Rd(Mem_Rd), .Mem_Data(Mem_Data), .Mem_Ready(Mem_Ready),
        .Alu_Valid(Alu_Valid), .Alu_Rd(Alu_Rd), .Alu_Data(Alu_Data), .Alu_Ready(Alu_Ready),
        .D(D), .En(En), .Pend(Pend), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // Advance one rising edge; return 1 time unit after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Mem_Valid = 1'b1; Mem_Rd = 5'd7; Mem_Data = 32'h1234_5678;
        Alu_Valid = 1'b0; Alu_Rd = 5'd0; Alu_Data = 32'h0;
        tick(); tick();
        n_checks++; if (En !== 32'h0) begin n_fail++; $display("FAIL reset_en got=%h exp=%h", En, 32'h0); end
        n_checks++; if (D !== 32'h0) begin n_fail++; $display("FAIL reset_d got=%h exp=%h", D, 32'h0); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        n_checks++; if (Mem_Ready !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ready got=%b exp=0", Mem_Ready); end
        n_checks++; if (Alu_Ready !== 1'b0) begin n_fail++; $display("FAIL reset_alu_ready got=%b exp=0", Alu_Ready); end
        Rst = 1'b0; #1;
        // Empty queue: free=4, so both sides are ready even with Mem_Valid=1
        n_checks++; if (Mem_Ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_mem_ready got=%b exp=1", Mem_Ready); end
        n_checks++; if (Alu_Ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_alu_ready got=%b exp=1", Alu_Ready); end
        Mem_Valid = 1'b0;
        tick();
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got=%b exp=0", Busy); end
    endtask

    task automatic test_single();
        Alu_Valid = 1'b1; Alu_Rd = 5'd5; Alu_Data = 32'hDEAD_BEEF; #1;
        n_checks++; if (Alu_Ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%b exp=1", Alu_Ready); end
        tick(); // edge 1: accepted
        Alu_Valid = 1'b0;
        n_checks++; if (Pend !== 32'h20) begin n_fail++; $display("FAIL single_pend_e1 got=%h exp=%h", Pend, 32'h20); end
        n_checks++; if (En !== 32'h0) begin n_fail++; $display("FAIL single_en_e1 got=%h exp=%h", En, 32'h0); end
        tick(); // edge 2: on En/D
        n_checks++; if (En !== 32'h20) begin n_fail++; $display("FAIL single_en_e2 got=%h exp=%h", En, 32'h20); end
        n_checks++; if (D !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_d_e2 got=%h exp=%h", D, 32'hDEAD_BEEF); end
        n_checks++; if (Pend !== 32'h20) begin n_fail++; $display("FAIL single_pend_e2 got=%h exp=%h", Pend, 32'h20); end
        tick(); // edge 3: gone
        n_checks++; if (En !== 32'h0) begin n_fail++; $display("FAIL single_en_e3 got=%h exp=%h", En, 32'h0); end
        n_checks++; if (D !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_d_hold got=%h exp=%h", D, 32'hDEAD_BEEF); end
        n_checks++; if (Pend !== 32'h0) begin n_fail++; $display("FAIL single_pend_e3 got=%h exp=%h", Pend, 32'h0); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_e3 got=%b exp=0", Busy); end
    endtask

    task automatic test_simultaneous();
        Mem_Valid = 1'b1; Mem_Rd = 5'd3; Mem_Data = 32'h11;
        Alu_Valid = 1'b1; Alu_Rd = 5'd3; Alu_Data = 32'h22; #1;
        n_checks++; if ({Mem_Ready, Alu_Ready} !== 2'b11) begin n_fail++; $display("FAIL simul_ready got=%b exp=11", {Mem_Ready, Alu_Ready}); end
        tick();
        Mem_Valid = 1'b0; Alu_Valid = 1'b0;
        n_checks++; if (Pend !== 32'h8) begin n_fail++; $display("FAIL simul_pend_q got=%h exp=%h", Pend, 32'h8); end
        tick();
        n_checks++; if (En !== 32'h8 || D !== 32'h11) begin n_fail++; $display("FAIL simul_first got=%h/%h exp=%h/%h", En, D, 32'h8, 32'h11); end
        n_checks++; if (Pend !== 32'h8) begin n_fail++; $display("FAIL simul_pend_mid got=%h exp=%h", Pend, 32'h8); end
        tick();
        n_checks++; if (En !== 32'h8 || D !== 32'h22) begin n_fail++; $display("FAIL simul_second got=%h/%h exp=%h/%h", En, D, 32'h8, 32'h22); end
        n_checks++; if (Pend !== 32'h8) begin n_fail++; $display("FAIL simul_pend_last got=%h exp=%h", Pend, 32'h8); end
        tick();
        n_checks++; if (En !== 32'h0 || Pend !== 32'h0) begin n_fail++; $display("FAIL simul_done got=%h/%h exp=0/0", En, Pend); end
    endtask

    task automatic test_full();
        logic [31:0] exp_d  [7];
        logic [31:0] exp_en [7];
        // Part 1: one push per edge, pops keep pace
        for (int k = 0; k < 4; k++) begin
            Mem_Valid = 1'b1; Mem_Rd = 5'(k + 1); Mem_Data = 32'h100 + 32'(k); #1;
            n_checks++; if (Mem_Ready !== 1'b1) begin n_fail++; $display("FAIL stream_mem_ready k=%0d got=%b exp=1", k, Mem_Ready); end
            tick();
            if (k >= 1) begin
                n_checks++;
                if (En !== (32'd1 << k) || D !== (32'h100 + 32'(k - 1))) begin
                    n_fail++; $display("FAIL stream_retire k=%0d got=%h/%h exp=%h/%h", k, En, D, 32'd1 << k, 32'h100 + 32'(k - 1));
                end
            end
        end
        Mem_Valid = 1'b0;
        tick();
        n_checks++; if (En !== 32'h10 || D !== 32'h103) begin n_fail++; $display("FAIL stream_last got=%h/%h exp=%h/%h", En, D, 32'h10, 32'h103); end
        tick();
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL stream_busy got=%b exp=0", Busy); end

        // Part 2: both sources valid; expected queue order M200,A0,M201,A1,M202,M203,A2
        exp_d  = '{32'h200, 32'hA0, 32'h201, 32'hA1, 32'h202, 32'h203, 32'hA2};
        exp_en = '{32'h200, 32'h400, 32'h200, 32'h400, 32'h200, 32'h200, 32'h400};
        Alu_Rd = 5'd10; Mem_Rd = 5'd9;
        for (int j = 0; j < 5; j++) begin
            Mem_Valid = (j < 4);
            Mem_Data  = 32'h200 + 32'(j);
            Alu_Valid = 1'b1;
            Alu_Data  = 32'hA0 + 32'((j < 2) ? j : 2);
            #1;
            // free: 4,2,1,1,1 -> ALU blocked when free==1 and the load competes
            n_checks++;
            if (Alu_Ready !== ((j < 2) || (j == 4))) begin
                n_fail++; $display("FAIL fill_alu_ready j=%0d got=%b exp=%b", j, Alu_Ready, (j < 2) || (j == 4));
            end
            if (j < 4) begin
                n_checks++; if (Mem_Ready !== 1'b1) begin n_fail++; $display("FAIL fill_mem_ready j=%0d got=%b exp=1", j, Mem_Ready); end
            end
            tick();
            if (j >= 1) begin
                n_checks++;
                if (En !== exp_en[j - 1] || D !== exp_d[j - 1]) begin
                    n_fail++; $display("FAIL fill_order e=%0d got=%h/%h exp=%h/%h", j - 1, En, D, exp_en[j - 1], exp_d[j - 1]);
                end
            end
        end
        Mem_Valid = 1'b0; Alu_Valid = 1'b0;
        for (int e = 4; e < 7; e++) begin
            tick();
            n_checks++;
            if (En !== exp_en[e] || D !== exp_d[e]) begin
                n_fail++; $display("FAIL fill_order e=%0d got=%h/%h exp=%h/%h", e, En, D, exp_en[e], exp_d[e]);
            end
        end
        tick();
        n_checks++; if (Busy !== 1'b0 || En !== 32'h0) begin n_fail++; $display("FAIL fill_drain got=%b/%h exp=0/0", Busy, En); end
    endtask

    task automatic test_r0();
        Alu_Valid = 1'b1; Alu_Rd = 5'd0; Alu_Data = 32'hFFFF_FFFF;
        tick();
        Alu_Valid = 1'b0;
        n_checks++; if (Busy !== 1'b1 || Pend !== 32'h0) begin n_fail++; $display("FAIL r0_queued got=%b/%h exp=1/0", Busy, Pend); end
        tick();
        n_checks++; if (En !== 32'h0 || Pend !== 32'h0) begin n_fail++; $display("FAIL r0_retire got=%h/%h exp=0/0", En, Pend); end
        n_checks++; if (D !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL r0_d got=%h exp=%h", D, 32'hFFFF_FFFF); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL r0_busy got=%b exp=0", Busy); end
    endtask

    task automatic test_reset_mid();
        Mem_Valid = 1'b1; Mem_Rd = 5'd12; Mem_Data = 32'h3C;
        Alu_Valid = 1'b1; Alu_Rd = 5'd13; Alu_Data = 32'h3D;
        tick(); // 2 queued
        Mem_Rd = 5'd14; Mem_Data = 32'h3E; Alu_Rd = 5'd15; Alu_Data = 32'h3F;
        tick(); // 3 queued, one on En
        n_checks++; if (Pend !== 32'h0000_F000) begin n_fail++; $display("FAIL mid_pend_before got=%h exp=%h", Pend, 32'h0000_F000); end
        Mem_Valid = 1'b0; Alu_Valid = 1'b0; Rst = 1'b1;
        tick();
        Rst = 1'b0;
        n_checks++; if (En !== 32'h0 || Busy !== 1'b0 || Pend !== 32'h0) begin n_fail++; $display("FAIL mid_reset got=%h/%b/%h exp=0/0/0", En, Busy, Pend); end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++; if (En !== 32'h0) begin n_fail++; $display("FAIL mid_no_write c=%0d got=%h exp=0", c, En); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_full();
        test_r0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
